// File: rtl/psum_accumulate_writer.sv
// psum_accumulate_writer: maps NoC psum tuples to GLB scratchpad addresses and writes
// or read-add-writes them, signalling done once the pass tuple count is reached.
module psum_accumulate_writer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int F_WIDTH    = 6,
  parameter int m_WIDTH    = 8,
  parameter int n_WIDTH    = 3,
  parameter int e_WIDTH    = 8,
  parameter int p_WIDTH    = 5,
  parameter int t_WIDTH    = 3,
  parameter int CNT_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  accumulate,
  input  logic [F_WIDTH-1:0]    F,
  input  logic [n_WIDTH-1:0]    n,
  input  logic [e_WIDTH-1:0]    e,
  input  logic [p_WIDTH-1:0]    p,
  input  logic [t_WIDTH-1:0]    t,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] psum_data,
  input  logic [n_WIDTH-1:0]    psum_index,
  input  logic [m_WIDTH-1:0]    channel_index,
  input  logic [e_WIDTH-1:0]    row_index,
  input  logic [F_WIDTH-1:0]    col_index,
  output logic                  glb_rd_en,
  output logic [ADDR_WIDTH-1:0] glb_rd_addr,
  input  logic [DATA_WIDTH-1:0] glb_rd_data,
  output logic                  glb_wr_en,
  output logic [ADDR_WIDTH-1:0] glb_wr_addr,
  output logic [DATA_WIDTH-1:0] glb_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  range_err
);
  localparam int PT_W   = p_WIDTH + t_WIDTH;
  localparam int FULL_W = m_WIDTH + e_WIDTH + F_WIDTH + n_WIDTH + 4;
  localparam int PROD_W = n_WIDTH + F_WIDTH + e_WIDTH + p_WIDTH + t_WIDTH + CNT_WIDTH;
  typedef enum logic [2:0] {IDLE, ACCEPT, READ, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [F_WIDTH-1:0]    f_r;
  logic [n_WIDTH-1:0]    n_r;
  logic [e_WIDTH-1:0]    e_r;
  logic [PT_W-1:0]       pt_r;
  logic [CNT_WIDTH-1:0]  total, count, count_inc, total_w;
  logic                  acc_r;
  logic [ADDR_WIDTH-1:0] rmw_addr, addr;
  logic [DATA_WIDTH-1:0] rmw_data;
  logic                  in_range, fire;
  // Address is formed at full precision before truncation so large passes alias predictably.
  assign addr = ADDR_WIDTH'(((FULL_W'(channel_index) * FULL_W'(e_r) + FULL_W'(row_index))
                * FULL_W'(f_r) + FULL_W'(col_index)) * FULL_W'(n_r) + FULL_W'(psum_index));
  assign total_w = CNT_WIDTH'(PROD_W'(n) * PROD_W'(F) * PROD_W'(e) * PROD_W'(p) * PROD_W'(t));
  assign in_range = (psum_index < n_r) && (col_index < f_r) && (row_index < e_r)
                  && (32'(channel_index) < 32'(pt_r));
  assign fire = (state == ACCEPT) && in_valid;
  assign count_inc = count + CNT_WIDTH'(1);
  always_comb begin
    state_nx    = state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    glb_rd_en   = 1'b0;
    glb_rd_addr = '0;
    glb_wr_en   = 1'b0;
    glb_wr_addr = '0;
    glb_wr_data = '0;
    case (state)
      IDLE: if (start) state_nx = (total_w == '0) ? DONE : ACCEPT;
      ACCEPT: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (in_range && acc_r) begin
            glb_rd_en   = 1'b1;
            glb_rd_addr = addr;
            state_nx    = READ;
          end else begin
            glb_wr_en   = in_range;
            glb_wr_addr = in_range ? addr : '0;
            glb_wr_data = in_range ? psum_data : '0;
            state_nx    = (count_inc == total) ? DONE : ACCEPT;
          end
        end
      end
      READ: begin
        busy     = 1'b1;
        state_nx = WRITE;
      end
      WRITE: begin
        busy        = 1'b1;
        glb_wr_en   = 1'b1;
        glb_wr_addr = rmw_addr;
        glb_wr_data = glb_rd_data + rmw_data;
        state_nx    = (count == total) ? DONE : ACCEPT;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  // Falling-edge state to line up with the NoC controller.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      f_r       <= '0;
      n_r       <= '0;
      e_r       <= '0;
      pt_r      <= '0;
      total     <= '0;
      count     <= '0;
      acc_r     <= 1'b0;
      rmw_addr  <= '0;
      rmw_data  <= '0;
      range_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        f_r       <= F;
        n_r       <= n;
        e_r       <= e;
        pt_r      <= PT_W'(p) * PT_W'(t);
        total     <= total_w;
        acc_r     <= accumulate;
        count     <= '0;
        range_err <= 1'b0;
      end
      if (fire) begin
        count <= count_inc;
        if (!in_range) range_err <= 1'b1;
        if (in_range && acc_r) begin
          rmw_addr <= addr;
          rmw_data <= psum_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_psum_accumulate_writer.sv
// tb_psum_accumulate_writer: directed and randomized passes checked against a
// tuple-level scratchpad model.
module tb_psum_accumulate_writer;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, accumulate = 1'b0;
  logic [5:0]  f_in = '0;
  logic [2:0]  n_in = '0;
  logic [7:0]  e_in = '0;
  logic [4:0]  p_in = '0;
  logic [2:0]  t_in = '0;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] psum_data = '0;
  logic [2:0]  psum_index = '0;
  logic [7:0]  channel_index = '0, row_index = '0;
  logic [5:0]  col_index = '0;
  logic        glb_rd_en, glb_wr_en, busy, done, range_err;
  logic [15:0] glb_rd_addr, glb_wr_addr, glb_wr_data, rd_q = '0;
  logic [15:0] mem [0:255];
  logic [15:0] exp_mem [0:255];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_a = '0;
  logic [15:0] pl_d = '0;
  int n_cmp = 0, n_bad = 0;
  int c_f, c_n, c_e, c_p, c_t, c_acc;
  bit exp_rerr, last_ir;
  int last_addr, stalls;

  psum_accumulate_writer dut (
    .clk(clk), .reset(reset), .start(start), .accumulate(accumulate),
    .F(f_in), .n(n_in), .e(e_in), .p(p_in), .t(t_in),
    .in_valid(in_valid), .in_ready(in_ready), .psum_data(psum_data),
    .psum_index(psum_index), .channel_index(channel_index), .row_index(row_index),
    .col_index(col_index), .glb_rd_en(glb_rd_en), .glb_rd_addr(glb_rd_addr),
    .glb_rd_data(rd_q), .glb_wr_en(glb_wr_en), .glb_wr_addr(glb_wr_addr),
    .glb_wr_data(glb_wr_data), .busy(busy), .done(done), .range_err(range_err)
  );

  always #5 clk = ~clk;

  // GLB model: falling-edge SRAM, read data held until the next read.
  always @(negedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (glb_wr_en) mem[glb_wr_addr[7:0]] <= glb_wr_data;
    if (glb_rd_en) rd_q <= mem[glb_rd_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic bit in_rng(int pi, int ci, int ri, int co);
    return pi < c_n && co < c_f && ri < c_e && ci < c_p * c_t;
  endfunction

  function automatic int lin_addr(int pi, int ci, int ri, int co);
    return ((ci * c_e + ri) * c_f + co) * c_n + pi;
  endfunction

  task automatic preload(input int a, input logic [15:0] d);
    @(posedge clk);
    pl_en = 1'b1; pl_a = 8'(a); pl_d = d;
    exp_mem[a] = d;
  endtask

  task automatic preload_off();
    @(posedge clk);
    pl_en = 1'b0;
  endtask

  task automatic start_pass(input int acc, input int f, input int nn, input int ee,
                            input int pp, input int tt);
    c_acc = acc; c_f = f; c_n = nn; c_e = ee; c_p = pp; c_t = tt;
    exp_rerr = 1'b0;
    last_ir = 1'b0;
    @(posedge clk);
    in_valid = 1'b0;
    accumulate = acc[0]; f_in = 6'(f); n_in = 3'(nn); e_in = 8'(ee); p_in = 5'(pp); t_in = 3'(tt);
    start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    #1;
    check("start_rerr_clear", range_err, 0);
    check("start_busy", busy, (f * nn * ee * pp * tt) != 0);
  endtask

  task automatic send(input logic [15:0] d, input int pi, input int ci, input int ri, input int co);
    bit got, ir;
    int a;
    got = 0;
    stalls = 0;
    ir = in_rng(pi, ci, ri, co);
    a = lin_addr(pi, ci, ri, co);
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk);
      in_valid = 1'b1; psum_data = d; psum_index = 3'(pi);
      channel_index = 8'(ci); row_index = 8'(ri); col_index = 6'(co);
      #1;
      if (in_ready) begin
        got = 1;
        check("hs_wr_en", glb_wr_en, ir && c_acc == 0);
        check("hs_rd_en", glb_rd_en, ir && c_acc == 1);
        last_addr = c_acc == 1 ? int'(glb_rd_addr) : int'(glb_wr_addr);
        if (ir) check("hs_addr", last_addr, a);
        if (ir && c_acc == 0) check("hs_wr_data", glb_wr_data, d);
        if (ir) exp_mem[a] = c_acc == 1 ? exp_mem[a] + d : d;
        else exp_rerr = 1'b1;
        last_ir = ir;
      end else stalls++;
    end
    if (!got) check("accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int k, want;
    want = (c_acc == 1 && last_ir) ? 3 : 1;
    for (k = 1; k <= 12; k++) begin
      @(posedge clk);
      in_valid = 1'b0;
      #1;
      if (done) break;
    end
    check("done_latency", k, want);
    check("done_busy", busy, 0);
    check("done_rerr", range_err, exp_rerr);
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 0);
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== exp_mem[a]) bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) preload(a, 16'h0);
    preload_off();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_strobes", {glb_rd_en, glb_wr_en, busy, done, range_err}, 0);
    check("rst_buses", {glb_rd_addr, glb_wr_addr, glb_wr_data}, 0);
    reset = 1'b0;

    // Plain write pass, back to back.
    start_pass(0, 2, 2, 1, 1, 1);
    send(16'd5, 0, 0, 0, 0); check("t1_stall", stalls, 0); check("t1_addr0", last_addr, 0);
    send(16'd6, 1, 0, 0, 0); check("t1_stall", stalls, 0); check("t1_addr1", last_addr, 1);
    send(16'd7, 0, 0, 0, 1); check("t1_stall", stalls, 0); check("t1_addr2", last_addr, 2);
    send(16'd8, 1, 0, 0, 1); check("t1_stall", stalls, 0); check("t1_addr3", last_addr, 3);
    wait_done();
    check_mem("t1_mem");

    // Accumulate pass over preloaded values.
    preload(0, 16'd10); preload(1, 16'd20); preload(2, 16'd30); preload(3, 16'd40);
    preload_off();
    start_pass(1, 2, 2, 1, 1, 1);
    send(16'd5, 0, 0, 0, 0);
    send(16'd6, 1, 0, 0, 0); check("t2_stall", stalls, 2);
    send(16'd7, 0, 0, 0, 1); check("t2_stall", stalls, 2);
    send(16'd8, 1, 0, 0, 1); check("t2_stall", stalls, 2);
    wait_done();
    check("t2_m0", mem[0], 16'd15);
    check("t2_m1", mem[1], 16'd26);
    check("t2_m2", mem[2], 16'd37);
    check("t2_m3", mem[3], 16'd48);
    check_mem("t2_mem");

    // Channel/row addressing.
    start_pass(0, 1, 1, 3, 2, 2);
    send(16'h0abc, 0, 3, 2, 0);
    check("t3_addr", last_addr, 11);
    for (int i = 0; i < 11; i++) send(16'($urandom), 0, $urandom_range(0, 3), $urandom_range(0, 2), 0);
    wait_done();
    check_mem("t3_mem");

    // Out-of-range column still counts and flags range_err.
    start_pass(0, 2, 1, 1, 1, 1);
    send(16'd9, 0, 0, 0, 2);
    send(16'd4, 0, 0, 0, 1);
    wait_done();
    check("t4_rerr", range_err, 1);
    check_mem("t4_mem");

    // Reset while an RMW is in flight.
    start_pass(1, 2, 2, 1, 1, 1);
    begin
      logic [15:0] saved;
      saved = exp_mem[0];
      send(16'd5, 0, 0, 0, 0);
      exp_mem[0] = saved;
    end
    @(posedge clk);
    #1;
    check("t5_in_read", busy, 1);
    reset = 1'b1;
    #1;
    check("t5_rst_out", {in_ready, glb_rd_en, glb_wr_en, busy, done, range_err}, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t5_no_wr", glb_wr_en, 0);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    check_mem("t5_mem_kept");
    start_pass(1, 1, 1, 1, 1, 1);
    send(16'd3, 0, 0, 0, 0);
    wait_done();
    check_mem("t5_after");

    // Wrapping add.
    preload(0, 16'hffff);
    preload_off();
    start_pass(1, 1, 1, 1, 1, 1);
    send(16'd2, 0, 0, 0, 0);
    wait_done();
    check("t6_wrap", mem[0], 16'h0001);

    // Zero-size pass goes straight to done.
    start_pass(0, 0, 1, 1, 1, 1);
    check("zero_done", done, 1);
    @(posedge clk);
    #1;
    check("zero_idle", {done, busy, in_ready}, 0);

    // Randomized passes.
    for (int r = 0; r < 10; r++) begin
      int f, nn, ee, pp, tt, tot;
      f = $urandom_range(1, 3); nn = $urandom_range(1, 3); ee = $urandom_range(1, 3);
      pp = $urandom_range(1, 2); tt = $urandom_range(1, 2);
      tot = f * nn * ee * pp * tt;
      start_pass($urandom_range(0, 1), f, nn, ee, pp, tt);
      for (int i = 0; i < tot; i++) begin
        int pi, ci, ri, co;
        pi = $urandom_range(0, nn - 1); ci = $urandom_range(0, pp * tt - 1);
        ri = $urandom_range(0, ee - 1); co = $urandom_range(0, f - 1);
        if ($urandom_range(0, 9) == 0) co = f + $urandom_range(0, 1);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          in_valid = 1'b0;
        end
        send(16'($urandom), pi, ci, ri, co);
      end
      wait_done();
      check_mem("rand_mem");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
